// File: rtl/mem_arbiter_if.sv
// Handshake bundle between mem_arbiter, the fetch/memory pipeline stages and the unified memory.
// master: arbiter side; slave: pipeline + memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_stall;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_stall, d_rdata, d_stall, mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_stall, d_rdata, d_stall, mem_req, mem_we, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported unified memory between fetch and memory stages, with timeout guard.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed data-over-instruction priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       timeout_hit;
    logic       pick_d;

    // wait_cnt counts completed BUSY cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

`ifdef MEM_ARB_RR_EN
    logic last_d;
    assign pick_d = bus.d_req & (~bus.i_req | ~last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE) begin
            if (pick_d)          last_d <= 1'b1;
            else if (bus.i_req)  last_d <= 1'b0;
        end
    end
`else
    assign pick_d = bus.d_req;
`endif

    assign bus.i_stall = bus.i_req & (state != RESP_I);
    assign bus.d_stall = bus.d_req & (state != RESP_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.i_rdata   <= '0;
            bus.d_rdata   <= '0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state         <= BUSY_D;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                    end else if (bus.i_req) begin
                        state         <= BUSY_I;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.i_addr;
                        bus.mem_wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready || timeout_hit) begin
                        // A timed-out read returns zero; stores never touch d_rdata
                        if (state == BUSY_I)
                            bus.i_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
                        else if (!bus.mem_we)
                            bus.d_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
                        if (!bus.mem_ready)
                            bus.err <= 1'b1;
                        state         <= (state == BUSY_I) ? RESP_I : RESP_D;
                        bus.mem_req   <= 1'b0;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP_I, RESP_D: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4); memory responses are driven by hand.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned errors = 0;
    int unsigned checks = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef MEM_ARB_RR_EN
    localparam logic FIRST_D = 1'b0;
`else
    localparam logic FIRST_D = 1'b1;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_addr1, exp_addr2, exp_d_rdata, exp_i_rdata;

    initial begin
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;

        // reset state
        #2;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_err", bus.err, 0);
        #10 rst = 0;
        tick();

        // lone fetch
        bus.i_req = 1; bus.i_addr = 32'h0040_0000;
        tick();
        check("fetch_mem_req", bus.mem_req, 1);
        check("fetch_mem_addr", bus.mem_addr, 32'h0040_0000);
        check("fetch_mem_we", bus.mem_we, 0);
        check("fetch_stall_busy", bus.i_stall, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h2008_0005;
        tick();
        check("fetch_stall_resp", bus.i_stall, 0);
        check("fetch_i_rdata", bus.i_rdata, 32'h2008_0005);
        check("fetch_mem_req_off", bus.mem_req, 0);
        bus.mem_ready = 0; bus.i_req = 0;
        tick();

        // data load, immediate ready
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1001_0010;
        tick();
        check("load_mem_addr", bus.mem_addr, 32'h1001_0010);
        check("load_mem_we", bus.mem_we, 0);
        bus.mem_ready = 1; bus.mem_rdata = 32'h1234_5678;
        tick();
        check("load_d_stall", bus.d_stall, 0);
        check("load_d_rdata", bus.d_rdata, 32'h1234_5678);
        bus.mem_ready = 0; bus.d_req = 0;
        tick();

        // store with three wait cycles
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0000; bus.d_wdata = 32'hCAFE_F00D;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("store_mem_req", bus.mem_req, 1);
            check("store_mem_we", bus.mem_we, 1);
            check("store_mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
            check("store_mem_addr", bus.mem_addr, 32'h1001_0000);
            check("store_d_stall", bus.d_stall, 1);
            if (k == 3) begin
                bus.mem_ready = 1; bus.mem_rdata = 32'hBAD0_BAD0;
            end
            tick();
        end
        check("store_resp_stall", bus.d_stall, 0);
        check("store_d_rdata_kept", bus.d_rdata, 32'h1234_5678);
        check("store_err", bus.err, 0);
        check("store_mem_we_off", bus.mem_we, 0);
        check("store_mem_wdata_off", bus.mem_wdata, 0);
        bus.mem_ready = 0; bus.d_req = 0; bus.d_we = 0;
        tick();

        // conflict: both requests in the same cycle (last grant was data)
        bus.i_req = 1; bus.i_addr = 32'h0040_0004;
        bus.d_req = 1; bus.d_addr = 32'h1001_0004;
        exp_addr1 = FIRST_D ? 32'h1001_0004 : 32'h0040_0004;
        exp_addr2 = FIRST_D ? 32'h0040_0004 : 32'h1001_0004;
        tick();
        check("conf_first_addr", bus.mem_addr, exp_addr1);
        bus.mem_ready = 1; bus.mem_rdata = 32'hAAAA_0001;
        tick();
        check("conf_first_d_stall", bus.d_stall, !FIRST_D);
        check("conf_first_i_stall", bus.i_stall, FIRST_D);
        if (FIRST_D) bus.d_req = 0; else bus.i_req = 0;
        bus.mem_ready = 0;
        tick();
        tick();
        check("conf_second_addr", bus.mem_addr, exp_addr2);
        bus.mem_ready = 1; bus.mem_rdata = 32'hBBBB_0002;
        tick();
        check("conf_second_d_stall", bus.d_stall, 0);
        check("conf_second_i_stall", bus.i_stall, 0);
        exp_d_rdata = FIRST_D ? 32'hAAAA_0001 : 32'hBBBB_0002;
        exp_i_rdata = FIRST_D ? 32'hBBBB_0002 : 32'hAAAA_0001;
        check("conf_d_rdata", bus.d_rdata, exp_d_rdata);
        check("conf_i_rdata", bus.i_rdata, exp_i_rdata);
        bus.mem_ready = 0; bus.i_req = 0; bus.d_req = 0;
        tick();

        // timeout on a load
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h1001_0008;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("to_busy_mem_req", bus.mem_req, 1);
            check("to_busy_err", bus.err, 0);
            check("to_busy_d_stall", bus.d_stall, 1);
            tick();
        end
        check("to_resp_d_stall", bus.d_stall, 0);
        check("to_d_rdata_zero", bus.d_rdata, 0);
        check("to_err_set", bus.err, 1);
        bus.d_req = 0;
        tick();
        tick();
        check("to_err_sticky", bus.err, 1);

        // mem_ready while idle is ignored
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        check("late_mem_req", bus.mem_req, 0);
        check("late_i_rdata", bus.i_rdata, exp_i_rdata);
        check("late_d_rdata", bus.d_rdata, 0);
        bus.mem_ready = 0;
        tick();

        // reset in the middle of a data access
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h1001_0020; bus.d_wdata = 32'h0000_0042;
        tick();
        check("mid_mem_req_before", bus.mem_req, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_mem_req", bus.mem_req, 0);
        check("mid_rst_mem_we", bus.mem_we, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        check("mid_rst_mem_wdata", bus.mem_wdata, 0);
        check("mid_rst_err", bus.err, 0);
        check("mid_rst_i_rdata", bus.i_rdata, 0);
        bus.d_req = 0; bus.d_we = 0;
        tick();
        rst = 0;
        bus.i_req = 1; bus.i_addr = 32'h0040_000C;
        tick();
        check("post_rst_addr", bus.mem_addr, 32'h0040_000C);
        check("post_rst_mem_req", bus.mem_req, 1);
        bus.mem_ready = 1; bus.mem_rdata = 32'h8C09_0000;
        tick();
        check("post_rst_i_stall", bus.i_stall, 0);
        check("post_rst_i_rdata", bus.i_rdata, 32'h8C09_0000);
        bus.mem_ready = 0; bus.i_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
